// File: rtl/ttl_serial_parity_tx.sv
// Serial frame transmitter: start bit, WIDTH data bits LSB first, generated parity, stop bit.
// Each registered output reflects the state it was computed from, so Q drops one edge after the load edge.
module ttl_serial_parity_tx #(
  parameter int WIDTH      = 8,
  parameter int DELAY_RISE = 0,
  parameter int DELAY_FALL = 0
) (
  input  logic             Clk,
  input  logic             Clear_bar,
  input  logic             Load_bar,
  input  logic             Odd,
  input  logic [WIDTH-1:0] D,
  output logic             Q,
  output logic             Busy,
  output logic             Done,
  output logic             Parity
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t           state;
  logic [WIDTH-1:0] shift;
  logic [CW-1:0]    cnt;
  logic             q_r;
  logic             busy_r;
  logic             done_r;
  logic             parity_r;

  // Even parity is the plain XOR chain; odd parity inverts it.
  function automatic logic gen_parity(input logic [WIDTH-1:0] d, input logic odd);
    return (^d) ^ odd;
  endfunction

  always_ff @(posedge Clk) begin
    if (!Clear_bar) begin
      state    <= IDLE;
      cnt      <= '0;
      q_r      <= 1'b1;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      parity_r <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          q_r    <= 1'b1;
          busy_r <= 1'b0;
          done_r <= 1'b0;
          if (!Load_bar) begin
            shift    <= D;
            parity_r <= gen_parity(D, Odd);
            state    <= START;
          end
        end
        START: begin
          q_r    <= 1'b0;
          busy_r <= 1'b1;
          done_r <= 1'b0;
          cnt    <= '0;
          state  <= DATA;
        end
        DATA: begin
          q_r    <= shift[0];
          busy_r <= 1'b1;
          done_r <= 1'b0;
          shift  <= shift >> 1;
          if (cnt == LAST_BIT) begin
            state <= PARITY;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        PARITY: begin
          q_r    <= parity_r;
          busy_r <= 1'b1;
          done_r <= 1'b0;
          state  <= STOP;
        end
        STOP: begin
          q_r    <= 1'b1;
          busy_r <= 1'b1;
          done_r <= 1'b1;
          // A load on the stop edge chains the next frame with no idle gap.
          if (!Load_bar) begin
            shift    <= D;
            parity_r <= gen_parity(D, Odd);
            state    <= START;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign #(q_r      ? DELAY_RISE : DELAY_FALL) Q      = q_r;
  assign #(busy_r   ? DELAY_RISE : DELAY_FALL) Busy   = busy_r;
  assign #(done_r   ? DELAY_RISE : DELAY_FALL) Done   = done_r;
  assign #(parity_r ? DELAY_RISE : DELAY_FALL) Parity = parity_r;

endmodule

// File: tb/tb_ttl_serial_parity_tx.sv
// Directed bench for ttl_serial_parity_tx: WIDTH=8 with rise/fall delays, plus a WIDTH=1 instance.
module tb_ttl_serial_parity_tx;

  logic       Clk = 1'b0;
  logic       Clear_bar = 1'b0;
  logic       Load_bar = 1'b1;
  logic       Odd = 1'b0;
  logic [7:0] D = 8'h00;
  logic       Q, Busy, Done, Parity;
  logic       Load1_bar = 1'b1;
  logic [0:0] D1 = 1'b0;
  logic       Q1, Busy1, Done1, Parity1;
  int         passed = 0;
  int         total = 0;

  always #10 Clk = ~Clk;

  ttl_serial_parity_tx #(.WIDTH(8), .DELAY_RISE(5), .DELAY_FALL(3)) dut (
    .Clk(Clk), .Clear_bar(Clear_bar), .Load_bar(Load_bar), .Odd(Odd), .D(D),
    .Q(Q), .Busy(Busy), .Done(Done), .Parity(Parity)
  );

  ttl_serial_parity_tx #(.WIDTH(1)) dut1 (
    .Clk(Clk), .Clear_bar(Clear_bar), .Load_bar(Load1_bar), .Odd(Odd), .D(D1),
    .Q(Q1), .Busy(Busy1), .Done(Done1), .Parity(Parity1)
  );

  task automatic step();
    @(posedge Clk);
    #8;
  endtask

  task automatic test_reset();
    Clear_bar = 1'b0; Load_bar = 1'b0; D = 8'hFF;
    step(); step();
    total++; if (Q !== 1'b1) $display("FAIL reset_q got %b want 1", Q); else passed++;
    total++; if (Busy !== 1'b0) $display("FAIL reset_busy got %b want 0", Busy); else passed++;
    total++; if (Done !== 1'b0) $display("FAIL reset_done got %b want 0", Done); else passed++;
    total++; if (Parity !== 1'b0) $display("FAIL reset_parity got %b want 0", Parity); else passed++;
    Clear_bar = 1'b1; Load_bar = 1'b1;
    step();
    total++; if (Busy !== 1'b0 || Q !== 1'b1) $display("FAIL reset_noframe got busy=%b q=%b want 0/1", Busy, Q); else passed++;
  endtask

  task automatic test_even();
    bit e[11];
    e = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 0, 1};
    D = 8'hA5; Odd = 1'b0; Load_bar = 1'b0;
    step();
    Load_bar = 1'b1;
    total++; if (Q !== 1'b1) $display("FAIL even_load_q got %b want 1", Q); else passed++;
    total++; if (Parity !== 1'b0) $display("FAIL even_parity got %b want 0", Parity); else passed++;
    for (int i = 0; i < 11; i++) begin
      step();
      total++; if (Q !== e[i]) $display("FAIL even_q[%0d] got %b want %b", i, Q, e[i]); else passed++;
      total++; if (Busy !== 1'b1) $display("FAIL even_busy[%0d] got %b want 1", i, Busy); else passed++;
      total++; if (Done !== (i == 10)) $display("FAIL even_done[%0d] got %b want %b", i, Done, (i == 10)); else passed++;
    end
    step();
    total++; if (Q !== 1'b1 || Busy !== 1'b0 || Done !== 1'b0)
      $display("FAIL even_idle got q=%b busy=%b done=%b want 1/0/0", Q, Busy, Done); else passed++;
  endtask

  task automatic test_odd();
    bit e[11];
    e = '{0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 1};
    D = 8'hA5; Odd = 1'b1; Load_bar = 1'b0;
    step();
    Load_bar = 1'b1;
    total++; if (Parity !== 1'b1) $display("FAIL odd_a5_parity got %b want 1", Parity); else passed++;
    for (int i = 0; i < 11; i++) begin
      step();
      if (i == 9) begin
        total++; if (Q !== 1'b1) $display("FAIL odd_a5_slot got %b want 1", Q); else passed++;
      end
    end
    step();
    D = 8'h01; Odd = 1'b0; Load_bar = 1'b0;
    step();
    Load_bar = 1'b1;
    total++; if (Parity !== 1'b1) $display("FAIL even_01_parity got %b want 1", Parity); else passed++;
    for (int i = 0; i < 11; i++) begin
      step();
      total++; if (Q !== e[i]) $display("FAIL even_01_q[%0d] got %b want %b", i, Q, e[i]); else passed++;
    end
    step();
  endtask

  task automatic test_back_to_back();
    bit e1[11];
    bit e2[11];
    e1 = '{0, 1, 1, 1, 1, 1, 1, 1, 1, 0, 1};
    e2 = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1};
    D = 8'hFF; Odd = 1'b0; Load_bar = 1'b0;
    step();
    D = 8'h00;
    for (int i = 0; i < 11; i++) begin
      step();
      total++; if (Q !== e1[i]) $display("FAIL b2b_first_q[%0d] got %b want %b", i, Q, e1[i]); else passed++;
    end
    Load_bar = 1'b1;
    for (int i = 0; i < 11; i++) begin
      step();
      total++; if (Q !== e2[i]) $display("FAIL b2b_second_q[%0d] got %b want %b", i, Q, e2[i]); else passed++;
      total++; if (Busy !== 1'b1) $display("FAIL b2b_busy[%0d] got %b want 1", i, Busy); else passed++;
      total++; if (Done !== (i == 10)) $display("FAIL b2b_done[%0d] got %b want %b", i, Done, (i == 10)); else passed++;
    end
    step();
    total++; if (Busy !== 1'b0) $display("FAIL b2b_idle got %b want 0", Busy); else passed++;
  endtask

  task automatic test_ignored_load();
    bit e[11];
    e = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 0, 1};
    D = 8'hA5; Odd = 1'b0; Load_bar = 1'b0;
    step();
    Load_bar = 1'b1;
    for (int i = 0; i < 11; i++) begin
      if (i == 4) begin
        Load_bar = 1'b0; D = 8'h00; Odd = 1'b1;
      end else begin
        Load_bar = 1'b1;
      end
      step();
      total++; if (Q !== e[i]) $display("FAIL ignload_q[%0d] got %b want %b", i, Q, e[i]); else passed++;
    end
    Load_bar = 1'b1;
    step();
    total++; if (Busy !== 1'b0) $display("FAIL ignload_idle got %b want 0", Busy); else passed++;
    total++; if (Parity !== 1'b0) $display("FAIL ignload_parity got %b want 0", Parity); else passed++;
    Odd = 1'b0;
  endtask

  task automatic test_abort();
    bit e[11];
    e = '{0, 0, 0, 1, 1, 1, 1, 0, 0, 1, 1};
    D = 8'hA5; Odd = 1'b0; Load_bar = 1'b0;
    step();
    Load_bar = 1'b1;
    for (int i = 0; i < 5; i++) step();
    total++; if (Q !== 1'b0) $display("FAIL abort_bit3 got %b want 0", Q); else passed++;
    Clear_bar = 1'b0;
    step();
    total++; if (Q !== 1'b1 || Busy !== 1'b0 || Done !== 1'b0)
      $display("FAIL abort_state got q=%b busy=%b done=%b want 1/0/0", Q, Busy, Done); else passed++;
    Clear_bar = 1'b1;
    step();
    total++; if (Busy !== 1'b0) $display("FAIL abort_stays_idle got %b want 0", Busy); else passed++;
    D = 8'h3C; Odd = 1'b1; Load_bar = 1'b0;
    step();
    Load_bar = 1'b1; Odd = 1'b0;
    total++; if (Parity !== 1'b1) $display("FAIL abort_next_parity got %b want 1", Parity); else passed++;
    for (int i = 0; i < 11; i++) begin
      step();
      total++; if (Q !== e[i]) $display("FAIL abort_next_q[%0d] got %b want %b", i, Q, e[i]); else passed++;
      total++; if (Done !== (i == 10)) $display("FAIL abort_next_done[%0d] got %b want %b", i, Done, (i == 10)); else passed++;
    end
    step();
  endtask

  task automatic test_delays();
    D = 8'hA5; Odd = 1'b0; Load_bar = 1'b0;
    step();
    Load_bar = 1'b1;
    @(posedge Clk);
    #2;
    total++; if (Q !== 1'b1) $display("FAIL delay_start_hold got %b want 1", Q); else passed++;
    #2;
    total++; if (Q !== 1'b0) $display("FAIL delay_start_fall got %b want 0", Q); else passed++;
    #4;
    for (int i = 1; i < 10; i++) step();
    @(posedge Clk);
    #2;
    total++; if (Q !== 1'b0) $display("FAIL delay_stop_hold2 got %b want 0", Q); else passed++;
    #2;
    total++; if (Q !== 1'b0) $display("FAIL delay_stop_hold4 got %b want 0", Q); else passed++;
    #2;
    total++; if (Q !== 1'b1) $display("FAIL delay_stop_rise got %b want 1", Q); else passed++;
    #2;
    step();
    total++; if (Busy !== 1'b0) $display("FAIL delay_idle got %b want 0", Busy); else passed++;
  endtask

  task automatic test_width1();
    bit e[4];
    e = '{0, 1, 1, 1};
    Odd = 1'b0; D1 = 1'b1; Load1_bar = 1'b0;
    step();
    Load1_bar = 1'b1;
    total++; if (Parity1 !== 1'b1) $display("FAIL w1_parity got %b want 1", Parity1); else passed++;
    for (int i = 0; i < 4; i++) begin
      step();
      total++; if (Q1 !== e[i]) $display("FAIL w1_q[%0d] got %b want %b", i, Q1, e[i]); else passed++;
      total++; if (Done1 !== (i == 3)) $display("FAIL w1_done[%0d] got %b want %b", i, Done1, (i == 3)); else passed++;
    end
    step();
    total++; if (Busy1 !== 1'b0) $display("FAIL w1_idle got %b want 0", Busy1); else passed++;
  endtask

  initial begin
    test_reset();
    test_even();
    test_odd();
    test_back_to_back();
    test_ignored_load();
    test_abort();
    test_delays();
    test_width1();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/ttl_serial_parity_tx.md
Name: ttl_serial_parity_tx

Overview:
- Clocked serial transmitter that generates the parity bit which the XNOR/XOR parity-checker gates verify at the receiving end.
- Loads a parallel word and shifts out one frame, LSB first: start bit, data bits, generated parity bit, stop bit.
- Parity polarity is selectable: even (XOR chain) or odd (XNOR chain).
- Sits in the 7400-style library as the source-side partner for parity-checked serial links in testbenches and composite designs.

Parameters:
WIDTH, 8, number of data bits per frame (>= 1)
DELAY_RISE, 0, output rise delay (simulation only)
DELAY_FALL, 0, output fall delay (simulation only)

Ports:
Clk  input  1  clock; all state changes on rising edge
Clear_bar  input  1  synchronous active-low reset
Load_bar  input  1  active-low start request; samples D and Odd
Odd  input  1  0 = even parity, 1 = odd parity; sampled with D
D  input  WIDTH  parallel data word
Q  output  1  serial line; idles high (mark)
Busy  output  1  high while a frame is in progress
Done  output  1  high for exactly the stop-bit cycle
Parity  output  1  parity bit of the last loaded word; held until next load

Behaviour:
- Reset: one clock and one reset only. Reset is synchronous, active-low, on Clk; Clear_bar is the only reset. Clear_bar low at a rising edge forces:
  - state IDLE, Q=1, Busy=0, Done=0, Parity=0.
  - Clear_bar has priority over Load_bar.
  - Clear_bar mid-frame aborts the frame immediately; no stop bit is sent.
- Outputs are registered. Q, Busy, Done and Parity drive through continuous assigns with #(DELAY_RISE, DELAY_FALL).
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - Q=1, Busy=0, Done=0.
  - Load_bar low at an edge: capture the shift register from D, capture Parity = ^D XOR Odd, go to START.
- START, 1 cycle: Q=0, Busy=1.
- DATA, WIDTH cycles:
  - Q = shift[0]; shift right each edge.
  - A bit counter, $clog2(WIDTH+1) bits, counts 0..WIDTH-1, then goes to PARITY.
- PARITY, 1 cycle: Q = Parity.
- STOP, 1 cycle: Q=1, Busy=1, Done=1.
  - Load_bar low at the edge ending STOP: accepted; go straight to START (back-to-back frames, no idle gap).
  - Otherwise go to IDLE.
- Load_bar in START, DATA or PARITY is ignored. D and Odd changes mid-frame have no effect.
- Frame length is WIDTH+3 cycles. Q goes low on the first edge after the load edge.
- Parity rule: the count of ones across data plus parity is even when Odd=0 and odd when Odd=1.
- Inputs X/Z at the load edge propagate X into the captured data and Parity. This is not masked.
- WIDTH=1: DATA lasts exactly 1 cycle.

Test Plan:
- Reset, WIDTH=8:
  - Hold Clear_bar=0 for 2 edges with Load_bar=0 -> Q=1, Busy=0, Done=0, Parity=0; no frame starts.
- Even frame:
  - Stimulus: D=8'hA5, Odd=0, Load_bar pulsed low for 1 edge.
  - Response: Q over the next 11 cycles = 0,1,0,1,0,0,1,0,1,0,1; Parity=0.
  - Busy high for 11 cycles; Done high only in cycle 11; then Q=1 idle.
- Odd frame:
  - Stimulus: D=8'hA5, Odd=1.
  - Response: parity slot Q=1, Parity=1.
  - Also D=8'h01, Odd=0 -> parity slot Q=1.
- Back-to-back and ignored load:
  - Load_bar held low continuously, D=8'hFF then 8'h00 -> second START follows STOP with no gap.
  - Load_bar low during DATA -> ignored; frame unchanged.
- Abort:
  - Clear_bar=0 during DATA bit 3 -> next cycle Q=1, Busy=0, Done=0.
  - A following load transmits a complete, correct frame.
- Delays:
  - DELAY_RISE=5, DELAY_FALL=3 -> Q falls 3 units after the START edge and rises 5 units after the STOP edge.
  - Q is still its old value 2 units after each edge.
